// File: rtl/wb_spi_if.sv
// rtl/wb_spi_if.sv - Wishbone slave bus bundle for the wb_spi SPI master
// Ports (as modports):
//   master: drives wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_sel_i, wb_dat_i;
//           samples wb_dat_o, wb_ack_o
//   slave : the reverse direction of every signal
interface wb_spi_if;
  logic        wb_cyc_i;
  logic        wb_stb_i;
  logic        wb_we_i;
  logic [1:0]  wb_adr_i;
  logic [3:0]  wb_sel_i;
  logic [31:0] wb_dat_i;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o;

  modport master (
    output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_sel_i, wb_dat_i,
    input  wb_dat_o, wb_ack_o
  );

  modport slave (
    input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_sel_i, wb_dat_i,
    output wb_dat_o, wb_ack_o
  );
endinterface

// File: rtl/wb_spi.sv
// rtl/wb_spi.sv - Wishbone-attached SPI mode-0 byte master
// Ports:
//   clk_i     system clock, rising edge
//   rst_i     asynchronous active-low reset
//   wb        Wishbone slave bundle (DATA=0, CTRL=1, STATUS=2, 3 reserved)
//   spi_sclk  SPI clock, idle low
//   spi_mosi  serial out, MSB first
//   spi_miso  serial in
//   spi_ss_n  software-controlled slave select, active low
//   interrupt transfer-complete level interrupt
module wb_spi #(
  parameter logic [7:0] DIV_RESET = 8'd4
) (
  input  logic      clk_i,
  input  logic      rst_i,
  wb_spi_if.slave   wb,
  output logic      spi_sclk,
  output logic      spi_mosi,
  input  logic      spi_miso,
  output logic      spi_ss_n,
  output logic      interrupt
);

  typedef enum logic [1:0] {IDLE, LOW, HIGH} state_t;

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  tx_q, tx_d;
  logic [7:0]  rx_sh_q, rx_sh_d;
  logic [7:0]  rx_q, rx_d;
  logic [7:0]  div_q, div_d;
  logic        ss_q, ss_d;
  logic        irq_en_q, irq_en_d;
  logic        done_q, done_d;
  logic        int_q, int_d;
  logic        sclk_q, sclk_d;
  logic        mosi_q, mosi_d;
  logic        ack_q, ack_d;
  logic [31:0] dat_q, dat_d;

  logic req, wr, rd, busy;

  // A new request is taken only when no ack is pending, so every access
  // gets exactly one single-cycle ack even with cyc/stb held high.
  assign req  = wb.wb_cyc_i & wb.wb_stb_i & ~ack_q;
  // Side effects commit at the end of the ack cycle, while the master
  // still holds address and data.
  assign wr   = ack_q & wb.wb_we_i;
  assign rd   = ack_q & ~wb.wb_we_i;
  assign busy = (state_q != IDLE);

  logic unused_ok;
  assign unused_ok = &{1'b0, wb.wb_sel_i[3:2], wb.wb_dat_i[31:10]};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    tx_d     = tx_q;
    rx_sh_d  = rx_sh_q;
    rx_d     = rx_q;
    div_d    = div_q;
    ss_d     = ss_q;
    irq_en_d = irq_en_q;
    done_d   = done_q;
    sclk_d   = sclk_q;
    mosi_d   = mosi_q;
    ack_d    = req;
    dat_d    = 32'd0;
    int_d    = done_q & irq_en_q;

    if (req) begin
      case (wb.wb_adr_i)
        2'd0:    dat_d = {24'd0, rx_q};
        2'd1:    dat_d = {22'd0, irq_en_q, ss_q, div_q};
        2'd2:    dat_d = {30'd0, done_q, busy};
        default: dat_d = 32'd0;
      endcase
    end

    if (wr && wb.wb_adr_i == 2'd1) begin
      if (wb.wb_sel_i[0]) div_d = wb.wb_dat_i[7:0];
      if (wb.wb_sel_i[1]) begin
        ss_d     = wb.wb_dat_i[8];
        irq_en_d = wb.wb_dat_i[9];
      end
    end

    // Cleared here first so that a completion in the same cycle wins below.
    if (rd && wb.wb_adr_i == 2'd0) done_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (wr && wb.wb_adr_i == 2'd0 && wb.wb_sel_i[0]) begin
          state_d = LOW;
          tx_d    = wb.wb_dat_i[7:0];
          mosi_d  = wb.wb_dat_i[7];
          bit_d   = 3'd0;
          done_d  = 1'b0;
          cnt_d   = div_q;
        end
      end
      LOW: begin
        if (cnt_q == 8'd0) begin
          state_d = HIGH;
          sclk_d  = 1'b1;
          rx_sh_d = {rx_sh_q[6:0], spi_miso};
          cnt_d   = div_q;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      HIGH: begin
        if (cnt_q == 8'd0) begin
          sclk_d = 1'b0;
          cnt_d  = div_q;
          if (bit_q == 3'd7) begin
            state_d = IDLE;
            rx_d    = rx_sh_q;
            done_d  = 1'b1;
          end else begin
            state_d = LOW;
            tx_d    = {tx_q[6:0], 1'b0};
            mosi_d  = tx_q[6];
            bit_d   = bit_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= IDLE;
      cnt_q    <= 8'd0;
      bit_q    <= 3'd0;
      tx_q     <= 8'd0;
      rx_sh_q  <= 8'd0;
      rx_q     <= 8'd0;
      div_q    <= DIV_RESET;
      ss_q     <= 1'b0;
      irq_en_q <= 1'b0;
      done_q   <= 1'b0;
      int_q    <= 1'b0;
      sclk_q   <= 1'b0;
      mosi_q   <= 1'b0;
      ack_q    <= 1'b0;
      dat_q    <= 32'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      tx_q     <= tx_d;
      rx_sh_q  <= rx_sh_d;
      rx_q     <= rx_d;
      div_q    <= div_d;
      ss_q     <= ss_d;
      irq_en_q <= irq_en_d;
      done_q   <= done_d;
      int_q    <= int_d;
      sclk_q   <= sclk_d;
      mosi_q   <= mosi_d;
      ack_q    <= ack_d;
      dat_q    <= dat_d;
    end
  end

  assign wb.wb_ack_o = ack_q;
  assign wb.wb_dat_o = dat_q;
  assign spi_sclk    = sclk_q;
  assign spi_mosi    = mosi_q;
  assign spi_ss_n    = ~ss_q;
  assign interrupt   = int_q;

endmodule

// File: tb/tb_wb_spi.sv
// tb/tb_wb_spi.sv - directed self-checking bench for wb_spi
module tb_wb_spi;
  logic clk_i = 1'b0;
  logic rst_i = 1'b0;
  logic spi_sclk, spi_mosi, spi_miso, spi_ss_n, interrupt;
  logic loop_en  = 1'b0;
  logic miso_val = 1'b0;
  int   checks = 0;
  int   errors = 0;
  logic [31:0] rdat;

  wb_spi_if bus ();

  always #5 clk_i = ~clk_i;

  assign spi_miso = loop_en ? spi_mosi : miso_val;

  wb_spi #(.DIV_RESET(8'd4)) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .wb       (bus),
    .spi_sclk (spi_sclk),
    .spi_mosi (spi_mosi),
    .spi_miso (spi_miso),
    .spi_ss_n (spi_ss_n),
    .interrupt(interrupt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drives one access at a negedge, holds it through the ack cycle, then releases.
  task automatic wb_access(input logic we, input logic [1:0] adr, input logic [3:0] sel,
                           input logic [31:0] wd, output logic [31:0] rd_o);
    logic got;
    got  = 1'b0;
    rd_o = 32'hxxxxxxxx;
    @(negedge clk_i);
    bus.wb_cyc_i = 1'b1;
    bus.wb_stb_i = 1'b1;
    bus.wb_we_i  = we;
    bus.wb_adr_i = adr;
    bus.wb_sel_i = sel;
    bus.wb_dat_i = wd;
    for (int i = 0; i < 8 && !got; i++) begin
      @(posedge clk_i); #1;
      if (bus.wb_ack_o === 1'b1) begin
        got  = 1'b1;
        rd_o = bus.wb_dat_o;
      end
    end
    check("ack_seen", {31'd0, got}, 32'd1);
    @(posedge clk_i); #1;
    bus.wb_cyc_i = 1'b0;
    bus.wb_stb_i = 1'b0;
    bus.wb_we_i  = 1'b0;
  endtask

  task automatic wb_write(input logic [1:0] adr, input logic [3:0] sel, input logic [31:0] wd);
    logic [31:0] dummy;
    wb_access(1'b1, adr, sel, wd, dummy);
  endtask

  // Watches sclk from just after the starting DATA write until the eighth falling edge.
  task automatic run_xfer(input int div, input logic [7:0] exp_tx, input string tag);
    int   rises, falls, last_fall;
    logic prev;
    logic timing_ok;
    logic [7:0] mo;
    rises = 0; falls = 0; last_fall = -1; timing_ok = 1'b1; mo = 8'd0;
    prev = spi_sclk;
    for (int c = 1; c <= 16 * (div + 1) + 40; c++) begin
      @(posedge clk_i); #1;
      if (spi_sclk && !prev) begin
        mo = {mo[6:0], spi_mosi};
        rises++;
        if (c != (2 * rises - 1) * (div + 1)) timing_ok = 1'b0;
      end
      if (!spi_sclk && prev) begin
        falls++;
        last_fall = c;
        if (c != 2 * falls * (div + 1)) timing_ok = 1'b0;
      end
      prev = spi_sclk;
      if (rises == 8 && !spi_sclk) break;
    end
    check({tag, "_rises"}, rises, 8);
    check({tag, "_mosi"}, {24'd0, mo}, {24'd0, exp_tx});
    check({tag, "_len"}, last_fall, 16 * (div + 1));
    check({tag, "_halfperiod"}, {31'd0, timing_ok}, 32'd1);
  endtask

  initial begin
    bus.wb_cyc_i = 1'b0;
    bus.wb_stb_i = 1'b0;
    bus.wb_we_i  = 1'b0;
    bus.wb_adr_i = 2'd0;
    bus.wb_sel_i = 4'd0;
    bus.wb_dat_i = 32'd0;

    #1;
    check("rst_sclk", {31'd0, spi_sclk}, 32'd0);
    check("rst_ss_n", {31'd0, spi_ss_n}, 32'd1);
    check("rst_ack", {31'd0, bus.wb_ack_o}, 32'd0);
    check("rst_dat", bus.wb_dat_o, 32'd0);
    repeat (3) @(negedge clk_i);
    rst_i = 1'b1;

    wb_access(1'b0, 2'd1, 4'hF, 32'd0, rdat); check("rst_ctrl", rdat, 32'h4);
    wb_access(1'b0, 2'd2, 4'hF, 32'd0, rdat); check("rst_status", rdat, 32'h0);
    check("rst_int", {31'd0, interrupt}, 32'd0);

    // div 0 loopback of 0xA5
    wb_write(2'd1, 4'b0011, 32'h300);
    check("ss_low", {31'd0, spi_ss_n}, 32'd0);
    loop_en = 1'b1;
    wb_write(2'd0, 4'b0001, 32'hA5);
    run_xfer(0, 8'hA5, "x0");
    @(posedge clk_i); #1;
    check("x0_int", {31'd0, interrupt}, 32'd1);
    wb_access(1'b0, 2'd2, 4'hF, 32'd0, rdat); check("x0_status", rdat, 32'h2);
    wb_access(1'b0, 2'd0, 4'hF, 32'd0, rdat); check("x0_rx", rdat, 32'hA5);
    repeat (2) @(posedge clk_i); #1;
    check("x0_int_clr", {31'd0, interrupt}, 32'd0);

    // div 3, miso high, send 0x00
    loop_en = 1'b0; miso_val = 1'b1;
    wb_write(2'd1, 4'b0011, 32'h103);
    wb_write(2'd0, 4'b0001, 32'h00);
    run_xfer(3, 8'h00, "x3");
    wb_access(1'b0, 2'd0, 4'hF, 32'd0, rdat); check("x3_rx", rdat, 32'hFF);
    check("x3_no_int", {31'd0, interrupt}, 32'd0);

    // DATA write while busy is ignored
    loop_en = 1'b1;
    wb_write(2'd0, 4'b0001, 32'hC3);
    wb_write(2'd0, 4'b0001, 32'h3C);
    wb_access(1'b0, 2'd2, 4'hF, 32'd0, rdat); check("busy_status", rdat, 32'h1);
    repeat (70) @(posedge clk_i);
    wb_access(1'b0, 2'd0, 4'hF, 32'd0, rdat); check("busy_rx", rdat, 32'hC3);
    wb_access(1'b0, 2'd2, 4'hF, 32'd0, rdat); check("busy_idle", rdat, 32'h0);

    // reserved address
    wb_write(2'd3, 4'hF, 32'hFFFFFFFF);
    wb_access(1'b0, 2'd3, 4'hF, 32'd0, rdat); check("rsv_read", rdat, 32'h0);
    wb_access(1'b0, 2'd1, 4'hF, 32'd0, rdat); check("rsv_ctrl", rdat, 32'h103);

    // back-to-back requests with cyc/stb held high
    begin
      int acks, consec;
      logic prev_ack;
      acks = 0; consec = 0; prev_ack = 1'b0;
      @(negedge clk_i);
      bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1; bus.wb_we_i = 1'b0; bus.wb_adr_i = 2'd2;
      for (int i = 0; i < 6; i++) begin
        @(posedge clk_i); #1;
        if (bus.wb_ack_o) acks++;
        if (bus.wb_ack_o && prev_ack) consec++;
        prev_ack = bus.wb_ack_o;
      end
      bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0;
      check("b2b_acks", acks, 3);
      check("b2b_consec", consec, 0);
    end

    // reset mid-transfer after bit 3
    loop_en = 1'b0; miso_val = 1'b1;
    wb_write(2'd0, 4'b0001, 32'hFF);
    repeat (34) @(posedge clk_i);
    #2 rst_i = 1'b0;
    #1;
    check("abort_sclk", {31'd0, spi_sclk}, 32'd0);
    check("abort_ss_n", {31'd0, spi_ss_n}, 32'd1);
    check("abort_int", {31'd0, interrupt}, 32'd0);
    @(negedge clk_i);
    rst_i = 1'b1;
    wb_access(1'b0, 2'd2, 4'hF, 32'd0, rdat); check("abort_status", rdat, 32'h0);
    wb_access(1'b0, 2'd0, 4'hF, 32'd0, rdat); check("abort_rx", rdat, 32'h0);
    wb_access(1'b0, 2'd1, 4'hF, 32'd0, rdat); check("abort_ctrl", rdat, 32'h4);
    repeat (20) @(posedge clk_i); #1;
    check("abort_quiet", {31'd0, spi_sclk}, 32'd0);

    // completion coincident with a DATA read keeps done set
    wb_write(2'd1, 4'b0011, 32'h300);
    loop_en = 1'b1;
    wb_write(2'd0, 4'b0001, 32'h5A);
    repeat (14) @(posedge clk_i);
    wb_access(1'b0, 2'd0, 4'hF, 32'd0, rdat);
    wb_access(1'b0, 2'd2, 4'hF, 32'd0, rdat); check("coinc_done", rdat, 32'h2);
    check("coinc_int", {31'd0, interrupt}, 32'd1);
    wb_access(1'b0, 2'd0, 4'hF, 32'd0, rdat); check("coinc_rx", rdat, 32'h5A);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
